// File: rtl/router_arbiter.sv
// Five-port input-buffered round-robin arbiter.
// Each port has a small FIFO. One registered output slot carries the winning
// packet and its one-hot source port. An all-zero packet means "no packet".

package pa_noc;
  localparam int APB_PACKET_WIDTH = 8;
endpackage

module router_arbiter
  import pa_noc::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        i_clk,
  input  logic                        i_arst_n,
  input  logic [APB_PACKET_WIDTH-1:0] i_local,
  input  logic [APB_PACKET_WIDTH-1:0] i_north,
  input  logic [APB_PACKET_WIDTH-1:0] i_south,
  input  logic [APB_PACKET_WIDTH-1:0] i_east,
  input  logic [APB_PACKET_WIDTH-1:0] i_west,
  input  logic                        i_ready,
  output logic [APB_PACKET_WIDTH-1:0] o_apbPacket,
  output logic [4:0]                  o_grant,
  output logic [4:0]                  o_full,
  output logic [4:0]                  o_overflow
);

  localparam int W  = APB_PACKET_WIDTH;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [W-1:0]  in_pkt [5];
  logic [W-1:0]  mem    [5][FIFO_DEPTH];
  logic [AW-1:0] rd_ptr [5];
  logic [AW-1:0] wr_ptr [5];
  logic [CW-1:0] count  [5];
  logic [2:0]    ptr;
  logic [4:0]    wr_en;
  logic [4:0]    pop;
  logic [4:0]    nonempty;
  logic          free;
  logic          grant_valid;
  logic [2:0]    winner;
  logic [3:0]    cand;

  assign in_pkt[0] = i_local;
  assign in_pkt[1] = i_north;
  assign in_pkt[2] = i_south;
  assign in_pkt[3] = i_east;
  assign in_pkt[4] = i_west;

  // Output slot can take a new packet when empty or being consumed.
  assign free = (o_apbPacket == '0) || i_ready;

  // Per-port write enable, occupancy and full decode from the registered count.
  always_comb begin
    wr_en    = '0;
    nonempty = '0;
    o_full   = '0;
    for (int p = 0; p < 5; p++) begin
      wr_en[p]    = (in_pkt[p] != '0) && (count[p] < DEPTH_C);
      nonempty[p] = (count[p] != '0);
      o_full[p]   = (count[p] == DEPTH_C);
    end
  end

  // Round-robin search from ptr upward, wrapping 4 -> 0.
  always_comb begin
    grant_valid = 1'b0;
    winner      = ptr;
    cand        = '0;
    for (int i = 0; i < 5; i++) begin
      cand = 4'(ptr) + 4'(i);
      if (cand > 4'd4) cand = cand - 4'd5;
      if (!grant_valid && nonempty[cand[2:0]]) begin
        grant_valid = 1'b1;
        winner      = cand[2:0];
      end
    end
    pop = (free && grant_valid) ? (5'b00001 << winner) : 5'b00000;
  end

  // FIFO pointers, counts and sticky drop flags.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int p = 0; p < 5; p++) begin
        count[p]  <= '0;
        rd_ptr[p] <= '0;
        wr_ptr[p] <= '0;
      end
      o_overflow <= '0;
    end else begin
      for (int p = 0; p < 5; p++) begin
        if (wr_en[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
        if (pop[p])   rd_ptr[p] <= rd_ptr[p] + 1'b1;
        count[p] <= count[p] + CW'(wr_en[p]) - CW'(pop[p]);
        // A full FIFO drops even if it pops this cycle: the decision uses the registered count.
        if ((in_pkt[p] != '0) && (count[p] == DEPTH_C)) o_overflow[p] <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge i_clk) begin
    for (int p = 0; p < 5; p++) begin
      if (wr_en[p]) mem[p][wr_ptr[p]] <= in_pkt[p];
    end
  end

  // Output slot, grant and priority pointer.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_apbPacket <= '0;
      o_grant     <= '0;
      ptr         <= '0;
    end else if (free) begin
      if (grant_valid) begin
        o_apbPacket <= mem[winner][rd_ptr[winner]];
        o_grant     <= 5'b00001 << winner;
        ptr         <= (winner == 3'd4) ? 3'd0 : winner + 3'd1;
      end else begin
        o_apbPacket <= '0;
        o_grant     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_router_arbiter.sv
// Directed bench for router_arbiter: latency, contention order, backpressure,
// overflow, fairness and asynchronous reset.
module tb_router_arbiter;
  import pa_noc::*;

  logic                        i_clk;
  logic                        i_arst_n;
  logic [APB_PACKET_WIDTH-1:0] i_local, i_north, i_south, i_east, i_west;
  logic                        i_ready;
  logic [APB_PACKET_WIDTH-1:0] o_apbPacket;
  logic [4:0]                  o_grant, o_full, o_overflow;

  int vectors = 0;
  int miscompares = 0;

  router_arbiter #(.FIFO_DEPTH(2)) dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n),
    .i_local(i_local), .i_north(i_north), .i_south(i_south),
    .i_east(i_east), .i_west(i_west), .i_ready(i_ready),
    .o_apbPacket(o_apbPacket), .o_grant(o_grant),
    .o_full(o_full), .o_overflow(o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    i_local = '0; i_north = '0; i_south = '0; i_east = '0; i_west = '0;
  endtask

  task automatic do_reset();
    i_arst_n = 1'b0;
    #3;
    i_arst_n = 1'b1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pkt, input logic [31:0] gnt);
    chk({tag, "_pkt"}, 32'(o_apbPacket), pkt);
    chk({tag, "_gnt"}, 32'(o_grant), gnt);
  endtask

  initial begin
    clear_inputs();
    i_ready  = 1'b1;
    i_arst_n = 1'b0;
    tick();
    tick();
    chk_out("reset", 0, 0);
    chk("reset_full", 32'(o_full), 0);
    chk("reset_ovf", 32'(o_overflow), 0);
    i_arst_n = 1'b1;

    // Single packet on east: visible two edges later, then gone.
    i_east = 8'h1D;
    tick();
    i_east = '0;
    chk_out("single_t1", 0, 0);
    tick();
    chk_out("single_t2", 8'h1D, 5'b01000);
    tick();
    chk_out("single_t3", 0, 0);

    // Contention from ptr = 0 after reset.
    do_reset();
    i_ready = 1'b1;
    i_local = 8'h11; i_north = 8'h22; i_south = 8'h33; i_east = 8'h44; i_west = 8'h55;
    tick();
    clear_inputs();
    tick(); chk_out("cont_l", 8'h11, 5'b00001);
    tick(); chk_out("cont_n", 8'h22, 5'b00010);
    tick(); chk_out("cont_s", 8'h33, 5'b00100);
    tick(); chk_out("cont_e", 8'h44, 5'b01000);
    tick(); chk_out("cont_w", 8'h55, 5'b10000);
    tick(); chk_out("cont_idle", 0, 0);
    // Pointer wrapped back to 0: local beats north.
    i_local = 8'h77; i_north = 8'h66;
    tick();
    clear_inputs();
    tick(); chk_out("wrap_l", 8'h77, 5'b00001);
    tick(); chk_out("wrap_n", 8'h66, 5'b00010);

    // Backpressure with three local packets.
    do_reset();
    i_ready = 1'b0;
    i_local = 8'hA1; tick();
    i_local = 8'hA2; tick();
    i_local = 8'hA3; tick();
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      chk_out("bp_hold", 8'hA1, 5'b00001);
      tick();
    end
    chk("bp_full", 32'(o_full), 5'b00001);
    i_ready = 1'b1;
    tick(); chk_out("bp_rel2", 8'hA2, 5'b00001);
    tick(); chk_out("bp_rel3", 8'hA3, 5'b00001);
    tick(); chk_out("bp_idle", 0, 0);

    // Overflow on north with DEPTH 2.
    do_reset();
    i_ready = 1'b0;
    i_north = 8'h01; tick();
    chk("ovf_full1", 32'(o_full), 0);
    i_north = 8'h02; tick();
    chk_out("ovf_out", 8'h01, 5'b00010);
    chk("ovf_full2", 32'(o_full), 0);
    i_north = 8'h03; tick();
    chk("ovf_full3", 32'(o_full), 5'b00010);
    chk("ovf_flag3", 32'(o_overflow), 0);
    i_north = 8'h04; tick();
    chk("ovf_flag4", 32'(o_overflow), 5'b00010);
    chk("ovf_full4", 32'(o_full), 5'b00010);
    clear_inputs();
    i_ready = 1'b1;
    tick(); chk_out("ovf_d2", 8'h02, 5'b00010);
    tick(); chk_out("ovf_d3", 8'h03, 5'b00010);
    tick(); chk_out("ovf_drop", 0, 0);
    chk("ovf_sticky", 32'(o_overflow), 5'b00010);
    chk("ovf_empty", 32'(o_full), 0);

    // Fairness between local and east.
    do_reset();
    chk("fair_ovf_clr", 32'(o_overflow), 0);
    i_ready = 1'b1;
    i_local = 8'h10; i_east = 8'h30;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick(); chk_out("fair_l", 8'h10, 5'b00001);
      tick(); chk_out("fair_e", 8'h30, 5'b01000);
    end
    clear_inputs();
    tick(); tick(); tick(); tick(); tick();

    // Asynchronous reset with packets buffered.
    do_reset();
    i_ready = 1'b0;
    i_local = 8'h05; i_north = 8'h06; i_south = 8'h07;
    tick();
    i_local = 8'h08;
    tick();
    clear_inputs();
    chk_out("mid_pre", 8'h05, 5'b00001);
    i_arst_n = 1'b0;
    #1;
    chk_out("mid_async", 0, 0);
    chk("mid_full", 32'(o_full), 0);
    #1;
    i_arst_n = 1'b1;
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out("mid_stale", 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
